// File: rtl/icache_fetch_scheduler.sv
// Fetch thread scheduler for the multithreaded I$. Each thread runs its own
// IDLE/RUN/MISS/HALT tracker; one thread per cycle is granted round-robin with a quantum.
module icache_fetch_thr_fsm (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic allow_i,
  input  logic active_i,
  input  logic stall_i,
  input  logic ready_i,
  input  logic xcpt_i,
  output logic elig_o,
  output logic busy_d_o,
  output logic halted_o
);
  typedef enum logic [1:0] {IDLE, RUN, MISS, HALT} thr_state_e;

  thr_state_e state_q, state_d;
  logic       halted_q;

  // Bus error wins over everything; a pending miss is tracked even if the thread is disabled.
  function automatic thr_state_e next_state(thr_state_e s, logic act, logic rdy, logic xcpt);
    thr_state_e n;
    n = s;
    if (xcpt) n = HALT;
    else begin
      case (s)
        IDLE:    if (act) n = RUN;
        RUN:     if (!rdy) n = MISS; else if (!act) n = IDLE;
        MISS:    if (rdy) n = RUN;
        default: if (!act) n = IDLE;
      endcase
    end
    return n;
  endfunction

  assign state_d  = next_state(state_q, active_i, ready_i, xcpt_i);
  assign elig_o   = (state_q == RUN) && ready_i && !stall_i && active_i && allow_i;
  assign busy_d_o = (state_d == RUN) || (state_d == MISS);
  assign halted_o = halted_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALT);
    end
  end
endmodule

module icache_fetch_scheduler #(
  parameter int NUM_THR = 4,
  parameter int TID_W   = 2,
  parameter int QUANTUM = 4,
  parameter int QCNT_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               mt_mode_i,
  input  logic [NUM_THR-1:0] thread_active_i,
  input  logic [NUM_THR-1:0] thread_stall_i,
  input  logic [NUM_THR-1:0] icache_ready_i,
  input  logic               xcpt_bus_error_i,
  input  logic [TID_W-1:0]   xcpt_thread_id_i,
  output logic               req_valid_o,
  output logic [TID_W-1:0]   req_thread_id_o,
  output logic [NUM_THR-1:0] thread_halted_o,
  output logic               all_idle_o
);
  logic [NUM_THR-1:0] elig, busy_d;
  logic               vld_q, vld_d, all_idle_q, mt_q;
  logic [TID_W-1:0]   tid_q, tid_d, ptr_q, ptr_d, cand;
  logic [QCNT_W-1:0]  qcnt_q, qcnt_d;
  logic               found;

  for (genvar t = 0; t < NUM_THR; t++) begin : g_thr
    icache_fetch_thr_fsm u_fsm (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .allow_i  ((t == 0) ? 1'b1 : mt_mode_i),
      .active_i (thread_active_i[t]),
      .stall_i  (thread_stall_i[t]),
      .ready_i  (icache_ready_i[t]),
      .xcpt_i   (xcpt_bus_error_i && (xcpt_thread_id_i == TID_W'(t))),
      .elig_o   (elig[t]),
      .busy_d_o (busy_d[t]),
      .halted_o (thread_halted_o[t])
    );
  end

  // Stay on the current thread until its quantum runs out, else rotate from ptr+1.
  always_comb begin
    vld_d  = 1'b0;
    tid_d  = tid_q;
    ptr_d  = ptr_q;
    qcnt_d = '0;
    cand   = '0;
    found  = 1'b0;
    if (vld_q && elig[tid_q] && (qcnt_q < QCNT_W'(QUANTUM - 1))) begin
      vld_d  = 1'b1;
      qcnt_d = qcnt_q + QCNT_W'(1);
    end else begin
      for (int i = 1; i <= NUM_THR; i++) begin
        cand = TID_W'((int'(ptr_q) + i) % NUM_THR);
        if (!found && elig[cand]) begin
          found = 1'b1;
          tid_d = cand;
          ptr_d = cand;
        end
      end
      vld_d = found;
    end
    if (mt_mode_i != mt_q) qcnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q      <= 1'b0;
      tid_q      <= '0;
      ptr_q      <= TID_W'(NUM_THR - 1);
      qcnt_q     <= '0;
      all_idle_q <= 1'b1;
    end else begin
      vld_q      <= vld_d;
      tid_q      <= tid_d;
      ptr_q      <= ptr_d;
      qcnt_q     <= qcnt_d;
      all_idle_q <= ~|busy_d;
    end
    mt_q <= mt_mode_i;
  end

  assign req_valid_o     = vld_q;
  assign req_thread_id_o = tid_q;
  assign all_idle_o      = all_idle_q;
endmodule

// File: tb/tb_icache_fetch_scheduler.sv
// Bench for icache_fetch_scheduler: two instances (quantum 4 and 1) driven in parallel,
// checked against a reference model plus a table of hand-derived grant sequences.
module tb_icache_fetch_scheduler;
  localparam int NT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, mt, xe;
  logic [NT-1:0] act, stall, rdy;
  logic [1:0]    xid;
  logic          v4, v1, i4, i1;
  logic [1:0]    t4, t1;
  logic [NT-1:0] h4, h1;

  icache_fetch_scheduler #(.NUM_THR(NT), .TID_W(2), .QUANTUM(4), .QCNT_W(3)) u_q4 (
    .clk_i(clk), .rst_ni(rst_n), .mt_mode_i(mt), .thread_active_i(act),
    .thread_stall_i(stall), .icache_ready_i(rdy), .xcpt_bus_error_i(xe),
    .xcpt_thread_id_i(xid), .req_valid_o(v4), .req_thread_id_o(t4),
    .thread_halted_o(h4), .all_idle_o(i4));

  icache_fetch_scheduler #(.NUM_THR(NT), .TID_W(2), .QUANTUM(1), .QCNT_W(3)) u_q1 (
    .clk_i(clk), .rst_ni(rst_n), .mt_mode_i(mt), .thread_active_i(act),
    .thread_stall_i(stall), .icache_ready_i(rdy), .xcpt_bus_error_i(xe),
    .xcpt_thread_id_i(xid), .req_valid_o(v1), .req_thread_id_o(t1),
    .thread_halted_o(h1), .all_idle_o(i1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // Reference model: thread states plus, per instance, the current burst length
  typedef enum int {S_IDLE, S_RUN, S_MISS, S_HALT} ms_e;
  ms_e ms[NT];
  bit  mv[2];
  int  mtid[2], mptr[2], mburst[2];
  bit  mmt = 1'b0;
  int  quant[2] = '{4, 1};

  task automatic model_edge();
    bit el[NT];
    int c;
    if (!rst_n) begin
      for (int t = 0; t < NT; t++) ms[t] = S_IDLE;
      for (int k = 0; k < 2; k++) begin
        mv[k] = 0; mtid[k] = 0; mptr[k] = NT - 1; mburst[k] = 0;
      end
    end else begin
      for (int t = 0; t < NT; t++)
        el[t] = (ms[t] == S_RUN) && rdy[t] && !stall[t] && act[t] && (mt || t == 0);
      for (int k = 0; k < 2; k++) begin
        if (mv[k] && el[mtid[k]] && (mburst[k] + 1 < quant[k])) begin
          mburst[k]++;
        end else begin
          mv[k] = 0;
          mburst[k] = 0;
          for (int j = 1; j <= NT; j++) begin
            c = (mptr[k] + j) % NT;
            if (!mv[k] && el[c]) begin
              mv[k] = 1; mtid[k] = c; mptr[k] = c;
            end
          end
        end
        if (mt != mmt) mburst[k] = 0;
      end
      for (int t = 0; t < NT; t++) begin
        if (xe && (int'(xid) == t)) ms[t] = S_HALT;
        else if (ms[t] == S_IDLE && act[t]) ms[t] = S_RUN;
        else if (ms[t] == S_RUN && !rdy[t]) ms[t] = S_MISS;
        else if (ms[t] == S_RUN && !act[t]) ms[t] = S_IDLE;
        else if (ms[t] == S_MISS && rdy[t]) ms[t] = S_RUN;
        else if (ms[t] == S_HALT && !act[t]) ms[t] = S_IDLE;
      end
    end
    mmt = mt;
  endtask

  task automatic step();
    logic [NT-1:0] eh;
    bit eidle;
    @(posedge clk);
    model_edge();
    #1;
    eidle = 1;
    for (int t = 0; t < NT; t++) begin
      eh[t] = (ms[t] == S_HALT);
      if (ms[t] == S_RUN || ms[t] == S_MISS) eidle = 0;
    end
    chk("vld_q4", 32'(v4), 32'(mv[0]));
    chk("tid_q4", 32'(t4), 32'(mtid[0]));
    chk("vld_q1", 32'(v1), 32'(mv[1]));
    chk("tid_q1", 32'(t1), 32'(mtid[1]));
    chk("halted_q4", 32'(h4), 32'(eh));
    chk("halted_q1", 32'(h1), 32'(eh));
    chk("idle_q4", 32'(i4), 32'(eidle));
    chk("idle_q1", 32'(i1), 32'(eidle));
  endtask

  typedef struct {
    bit            rst_n;
    bit            mt;
    logic [NT-1:0] act;
    bit            vld;
    int            tid4;
    int            tid1;
    bit            idle;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit m, input logic [NT-1:0] a, input bit v,
                     input int e4, input int e1, input bit idl);
    vec_t x;
    x.rst_n = r; x.mt = m; x.act = a; x.vld = v; x.tid4 = e4; x.tid1 = e1; x.idle = idl;
    tbl.push_back(x);
  endtask

  initial begin
    bit found;
    rst_n = 0; mt = 0; act = '0; stall = '0; rdy = '1; xe = 0; xid = '0;

    // Reset, single-thread start, then MT bursts of 4 vs fine-grain rotation
    add(0, 0, 4'b0001, 0, 0, 0, 1);
    add(0, 0, 4'b0001, 0, 0, 0, 1);
    add(1, 0, 4'b0001, 0, 0, 0, 0);
    add(1, 0, 4'b0001, 1, 0, 0, 0);
    add(1, 0, 4'b0001, 1, 0, 0, 0);
    add(1, 1, 4'b0011, 1, 0, 0, 0);
    add(1, 1, 4'b0011, 1, 0, 1, 0);
    add(1, 1, 4'b0011, 1, 0, 0, 0);
    add(1, 1, 4'b0011, 1, 0, 1, 0);
    add(1, 1, 4'b0011, 1, 1, 0, 0);
    add(1, 1, 4'b0011, 1, 1, 1, 0);
    add(1, 1, 4'b0011, 1, 1, 0, 0);
    add(1, 1, 4'b0011, 1, 1, 1, 0);
    add(1, 1, 4'b0011, 1, 0, 0, 0);
    add(1, 1, 4'b1111, 1, 0, 1, 0);
    add(1, 1, 4'b1111, 1, 0, 2, 0);
    add(1, 1, 4'b1111, 1, 0, 3, 0);
    add(1, 1, 4'b1111, 1, 1, 0, 0);
    add(1, 1, 4'b1111, 1, 1, 1, 0);
    add(1, 1, 4'b1111, 1, 1, 2, 0);
    add(1, 1, 4'b1111, 1, 1, 3, 0);
    add(1, 1, 4'b1111, 1, 2, 0, 0);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; mt = tbl[i].mt; act = tbl[i].act;
      step();
      chk($sformatf("tbl%0d_vld", i), 32'(v4), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_vld1", i), 32'(v1), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_tid4", i), 32'(t4), tbl[i].tid4);
      chk($sformatf("tbl%0d_tid1", i), 32'(t1), tbl[i].tid1);
      chk($sformatf("tbl%0d_idle", i), 32'(i4), 32'(tbl[i].idle));
      chk($sformatf("tbl%0d_halt", i), 32'(h4), 32'(0));
    end

    // Thread 1 misses for 10 cycles, then must come back within a rotation
    rdy = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("miss_t1_absent_q4", 32'(v4 && t4 == 2'd1), 32'(0));
      chk("miss_t1_absent_q1", 32'(v1 && t1 == 2'd1), 32'(0));
    end
    rdy = 4'b1111;
    found = 0;
    for (int i = 0; i < NT + 1; i++) begin
      step();
      if (v1 && t1 == 2'd1) found = 1;
    end
    chk("miss_t1_regrant_q1", 32'(found), 32'(1));

    // Bus error on thread 2 in the same cycle its fill returns
    rdy = 4'b1011;
    repeat (3) step();
    rdy = 4'b1111; xe = 1; xid = 2'd2;
    step();
    chk("xcpt_halted_q4", 32'(h4), 32'(4'b0100));
    chk("xcpt_halted_q1", 32'(h1), 32'(4'b0100));
    xe = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("xcpt_t2_absent_q4", 32'(v4 && t4 == 2'd2), 32'(0));
      chk("xcpt_t2_absent_q1", 32'(v1 && t1 == 2'd2), 32'(0));
    end
    chk("xcpt_still_halted", 32'(h4), 32'(4'b0100));
    act = 4'b1011;
    step();
    chk("xcpt_halt_cleared", 32'(h4), 32'(0));
    act = 4'b1111;
    repeat (3) step();

    // Reset while threads 1 and 3 are waiting on misses
    rdy = 4'b0101;
    repeat (2) step();
    rst_n = 0;
    step();
    chk("rst_miss_vld_q4", 32'(v4), 32'(0));
    chk("rst_miss_vld_q1", 32'(v1), 32'(0));
    chk("rst_miss_halted", 32'(h4), 32'(0));
    chk("rst_miss_idle_q4", 32'(i4), 32'(1));
    chk("rst_miss_idle_q1", 32'(i1), 32'(1));
    chk("rst_miss_tid", 32'(t4), 32'(0));
    rst_n = 1; rdy = 4'b1111;

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 49) == 0) mt = ~mt;
      if ($urandom_range(0, 15) == 0) act = 4'($urandom);
      for (int t = 0; t < NT; t++) begin
        stall[t] = ($urandom_range(0, 3) == 0);
        rdy[t]   = ($urandom_range(0, 5) != 0);
      end
      xe  = ($urandom_range(0, 39) == 0);
      xid = 2'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
